// File: rtl/trap_pkg.sv
// Shared cause codes, mtvec modes, FSM state type and a lowest-set-bit helper
// for the trap sequencer.
package trap_pkg;

  localparam logic [3:0] INST_MISALIGN = 4'd0;
  localparam logic [3:0] ILLEGAL       = 4'd2;
  localparam logic [3:0] BREAKPOINT    = 4'd3;
  localparam logic [3:0] ECALL_M       = 4'd11;

  localparam logic [3:0] MSI = 4'd3;
  localparam logic [3:0] MTI = 4'd7;
  localparam logic [3:0] MEI = 4'd11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } trap_state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/trap_priority_encoder.sv
// Picks the winning trap: lowest-index exception first, then enabled
// interrupts in the order MEI, MSI, MTI, then the rest lowest-index first.
module trap_priority_encoder
  import trap_pkg::*;
(
  input  logic [15:0] excReq,
  input  logic [15:0] irqPending,
  input  logic        mstatusMIE,
  output logic        valid,
  output logic        isInterrupt,
  output logic [3:0]  code
);

  localparam logic [15:0] FIXED_IRQ = (16'd1 << MEI) | (16'd1 << MSI) | (16'd1 << MTI);

  always_comb begin
    valid       = 1'b0;
    isInterrupt = 1'b0;
    code        = 4'd0;
    if (|excReq) begin
      valid = 1'b1;
      code  = lowest_set(excReq);
    end else if (mstatusMIE && (|irqPending)) begin
      valid       = 1'b1;
      isInterrupt = 1'b1;
      if (irqPending[MEI])      code = MEI;
      else if (irqPending[MSI]) code = MSI;
      else if (irqPending[MTI]) code = MTI;
      else                      code = lowest_set(irqPending & ~FIXED_IRQ);
    end
  end

endmodule

// File: rtl/trap_control.sv
// Trap sequencer: accepts traps/mret in IDLE, drains the pipeline, then redirects fetch.
// Optional macro TRAP_VECTORED_MODE_EN enables vectored interrupt targets.
module trap_control
  import trap_pkg::*;
#(
  parameter int N            = 64,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  excReq,
  input  logic [N-1:0] excPC,
  input  logic [N-1:0] excTval,
  input  logic [15:0]  irqPending,
  input  logic         mstatusMIE,
  input  logic         mretReq,
  input  logic [N-1:0] mtvec,
  input  logic [2:0]   csrWriteEnable,
  input  logic [N-1:0] csrIn,
  output logic [15:0]  trapTrigger,
  output logic         trapReturn,
  output logic         flush,
  output logic         busy,
  output logic         redirectValid,
  output logic [N-1:0] redirectPC,
  output logic [N-1:0] mepc,
  output logic [N-1:0] mcause,
  output logic [N-1:0] mtval
);

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  trap_state_t  state_reg, state_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic [15:0]  trigger_reg;
  logic         return_reg;
  logic [N-1:0] target_reg;
  logic [N-1:0] mepc_reg, mcause_reg, mtval_reg;

  logic         pe_valid, pe_is_int;
  logic [3:0]   pe_code;
  logic         accept_trap, accept_mret;
  logic [N-1:0] trap_base, trap_target;

  trap_priority_encoder u_prio (
    .excReq      (excReq),
    .irqPending  (irqPending),
    .mstatusMIE  (mstatusMIE),
    .valid       (pe_valid),
    .isInterrupt (pe_is_int),
    .code        (pe_code)
  );

  assign accept_trap = (state_reg == IDLE) && pe_valid;
  assign accept_mret = (state_reg == IDLE) && !pe_valid && mretReq;
  assign trap_base   = {mtvec[N-1:2], 2'b00};

`ifdef TRAP_VECTORED_MODE_EN
  always_comb begin
    trap_target = trap_base;
    if (pe_is_int && (mtvec[1:0] == MTVEC_VECTORED))
      trap_target = trap_base + {{(N-6){1'b0}}, pe_code, 2'b00};
  end
`else
  assign trap_target = trap_base;
`endif

  logic unused_bits;
  assign unused_bits = ^{excPC[1:0], mtvec[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept_trap || accept_mret) begin
          state_next = DRAIN;
          cnt_next   = CNT_INIT;
        end
      end
      DRAIN: begin
        if (cnt_reg == 4'd0) state_next = REDIRECT;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Trap acceptance takes precedence over a software write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      trigger_reg <= '0;
      return_reg  <= 1'b0;
      target_reg  <= '0;
      mepc_reg    <= '0;
      mcause_reg  <= '0;
      mtval_reg   <= '0;
    end else begin
      trigger_reg <= accept_trap ? (16'd1 << pe_code) : 16'd0;
      return_reg  <= accept_mret;

      if (accept_trap)      target_reg <= trap_target;
      else if (accept_mret) target_reg <= mepc_reg;

      if (accept_trap)            mepc_reg <= {excPC[N-1:2], 2'b00};
      else if (csrWriteEnable[0]) mepc_reg <= {csrIn[N-1:2], 2'b00};

      if (accept_trap)            mcause_reg <= {pe_is_int, {(N-5){1'b0}}, pe_code};
      else if (csrWriteEnable[1]) mcause_reg <= csrIn;

      if (accept_trap)            mtval_reg <= pe_is_int ? '0 : excTval;
      else if (csrWriteEnable[2]) mtval_reg <= csrIn;
    end
  end

  assign trapTrigger   = trigger_reg;
  assign trapReturn    = return_reg;
  assign flush         = (state_reg == DRAIN);
  assign busy          = (state_reg != IDLE);
  assign redirectValid = (state_reg == REDIRECT);
  assign redirectPC    = redirectValid ? target_reg : '0;
  assign mepc          = mepc_reg;
  assign mcause        = mcause_reg;
  assign mtval         = mtval_reg;

endmodule

// File: tb/tb_trap_control.sv
// Directed bench for trap_control with hand-computed expectations.
module tb_trap_control;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  excReq;
  logic [N-1:0] excPC, excTval;
  logic [15:0]  irqPending;
  logic         mstatusMIE, mretReq;
  logic [N-1:0] mtvec;
  logic [2:0]   csrWriteEnable;
  logic [N-1:0] csrIn;
  logic [15:0]  trapTrigger;
  logic         trapReturn, flush, busy, redirectValid;
  logic [N-1:0] redirectPC, mepc, mcause, mtval;

  int errors = 0;
  int checks = 0;

  trap_control #(.N(N), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .excReq(excReq), .excPC(excPC), .excTval(excTval),
    .irqPending(irqPending), .mstatusMIE(mstatusMIE), .mretReq(mretReq), .mtvec(mtvec),
    .csrWriteEnable(csrWriteEnable), .csrIn(csrIn), .trapTrigger(trapTrigger),
    .trapReturn(trapReturn), .flush(flush), .busy(busy), .redirectValid(redirectValid),
    .redirectPC(redirectPC), .mepc(mepc), .mcause(mcause), .mtval(mtval)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    excReq = '0; irqPending = '0; mretReq = 1'b0; csrWriteEnable = '0;
  endtask

  logic [N-1:0] vec_exp;

  initial begin
    reset = 1'b1; excPC = '0; excTval = '0; mstatusMIE = 1'b0; mtvec = '0; csrIn = '0;
    clear_inputs();
    step(); step();
    chk("rst_trig", 64'(trapTrigger), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_flush", 64'(flush), 64'h0);
    chk("rst_rv", 64'(redirectValid), 64'h0);
    chk("rst_mepc", mepc, 64'h0);
    chk("rst_mcause", mcause, 64'h0);
    reset = 1'b0;
    step();
    $display("txn reset done");

    // Exception 2
    excReq = 16'h0004; excPC = 64'h1006; excTval = 64'hDEAD; mtvec = 64'h8000_0000;
    step(); clear_inputs();
    chk("e2_trig", 64'(trapTrigger), 64'h0004);
    chk("e2_mepc", mepc, 64'h1004);
    chk("e2_mcause", mcause, 64'd2);
    chk("e2_mtval", mtval, 64'hDEAD);
    chk("e2_flush1", 64'(flush), 64'h1);
    chk("e2_busy1", 64'(busy), 64'h1);
    step();
    chk("e2_trig_off", 64'(trapTrigger), 64'h0);
    chk("e2_flush2", 64'(flush), 64'h1);
    step();
    chk("e2_flush3", 64'(flush), 64'h1);
    chk("e2_rv3", 64'(redirectValid), 64'h0);
    step();
    chk("e2_rv", 64'(redirectValid), 64'h1);
    chk("e2_rpc", redirectPC, 64'h8000_0000);
    chk("e2_flush4", 64'(flush), 64'h0);
    chk("e2_busy4", 64'(busy), 64'h1);
    step();
    chk("e2_idle", 64'(busy), 64'h0);
    chk("e2_rv_off", 64'(redirectValid), 64'h0);
    $display("txn exception2 mcause=%0d redirect checked", mcause);

    // Interrupts 7 and 11: MEI wins
    irqPending = 16'h0880; mstatusMIE = 1'b1; excTval = 64'h1234;
    step(); clear_inputs();
    chk("irq_trig", 64'(trapTrigger), 64'h0800);
    chk("irq_mcause", mcause, 64'h8000_0000_0000_000B);
    chk("irq_mtval", mtval, 64'h0);
    step(); step(); step();
    chk("irq_rpc", redirectPC, 64'h8000_0000);
    step();
    // Same with interrupts disabled: nothing happens
    irqPending = 16'h0880; mstatusMIE = 1'b0;
    step();
    chk("mie0_busy", 64'(busy), 64'h0);
    chk("mie0_trig", 64'(trapTrigger), 64'h0);
    step();
    chk("mie0_busy2", 64'(busy), 64'h0);
    chk("mie0_mcause", mcause, 64'h8000_0000_0000_000B);
    clear_inputs();
    $display("txn interrupt mei and masked interrupt");

    // Exception beats interrupt and mret
    excReq = 16'h0800; irqPending = 16'h0080; mstatusMIE = 1'b1; mretReq = 1'b1; excTval = 64'h55;
    step(); clear_inputs();
    chk("pri_trig", 64'(trapTrigger), 64'h0800);
    chk("pri_ret", 64'(trapReturn), 64'h0);
    chk("pri_mcause", mcause, 64'd11);
    chk("pri_mtval", mtval, 64'h55);
    step();
    chk("pri_ret2", 64'(trapReturn), 64'h0);
    step(); step();
    chk("pri_rpc", redirectPC, 64'h8000_0000);
    chk("pri_ret4", 64'(trapReturn), 64'h0);
    step();
    $display("txn priority exception11 over irq and mret");

    // CSR write then mret
    csrWriteEnable = 3'b001; csrIn = 64'h2003;
    step(); clear_inputs();
    chk("csr_mepc", mepc, 64'h2000);
    chk("csr_busy", 64'(busy), 64'h0);
    mretReq = 1'b1;
    step(); clear_inputs();
    chk("mret_ret", 64'(trapReturn), 64'h1);
    chk("mret_trig", 64'(trapTrigger), 64'h0);
    chk("mret_flush", 64'(flush), 64'h1);
    csrWriteEnable = 3'b001; csrIn = 64'h3000;
    step(); clear_inputs();
    chk("mret_ret_off", 64'(trapReturn), 64'h0);
    step();
    step();
    chk("mret_rv", 64'(redirectValid), 64'h1);
    chk("mret_rpc", redirectPC, 64'h2000);
    chk("mret_mepc_wr", mepc, 64'h3000);
    step();
    csrWriteEnable = 3'b110; csrIn = 64'hA5A5_0000_0000_0003;
    step(); clear_inputs();
    chk("csr_mcause", mcause, 64'hA5A5_0000_0000_0003);
    chk("csr_mtval", mtval, 64'hA5A5_0000_0000_0003);
    $display("txn csr writes and mret");

    // Vectored interrupt 7
    mtvec = 64'h8000_0001; irqPending = 16'h0080; mstatusMIE = 1'b1;
    step(); clear_inputs();
    chk("vec_trig", 64'(trapTrigger), 64'h0080);
    chk("vec_mcause", mcause, 64'h8000_0000_0000_0007);
    step(); step(); step();
`ifdef TRAP_VECTORED_MODE_EN
    vec_exp = 64'h8000_001C;
`else
    vec_exp = 64'h8000_0000;
`endif
    chk("vec_rpc_irq", redirectPC, vec_exp);
    step();
    excReq = 16'h0004; excPC = 64'h40;
    step(); clear_inputs();
    step(); step(); step();
    chk("vec_rpc_exc", redirectPC, 64'h8000_0000);
    step();
    $display("txn vectored irq and exception targets");

    // Trap acceptance beats a same-cycle CSR write; excReq during DRAIN ignored
    mtvec = 64'h9000_0000; excReq = 16'h0008; excTval = 64'h77;
    csrWriteEnable = 3'b111; csrIn = 64'hFFFF;
    step(); clear_inputs();
    chk("win_mcause", mcause, 64'd3);
    chk("win_mtval", mtval, 64'h77);
    chk("win_mepc", mepc, 64'h40);
    step();
    excReq = 16'h0001; excTval = 64'h99;
    step(); clear_inputs();
    chk("drain_mcause", mcause, 64'd3);
    chk("drain_mtval", mtval, 64'h77);
    chk("drain_trig", 64'(trapTrigger), 64'h0);
    step();
    chk("drain_rpc", redirectPC, 64'h9000_0000);
    step();
    chk("drain_idle", 64'(busy), 64'h0);
    step();
    chk("drain_idle2", 64'(busy), 64'h0);
    $display("txn csr-vs-trap and ignored drain request");

    // Reset during DRAIN
    excReq = 16'h0004; excPC = 64'h5004;
    step(); clear_inputs();
    step();
    reset = 1'b1;
    step();
    chk("rd_busy", 64'(busy), 64'h0);
    chk("rd_flush", 64'(flush), 64'h0);
    chk("rd_rv", 64'(redirectValid), 64'h0);
    chk("rd_mepc", mepc, 64'h0);
    chk("rd_mcause", mcause, 64'h0);
    chk("rd_mtval", mtval, 64'h0);
    reset = 1'b0;
    step();
    chk("rd_rv2", 64'(redirectValid), 64'h0);
    chk("rd_trig2", 64'(trapTrigger), 64'h0);
    step();
    chk("rd_rv3", 64'(redirectValid), 64'h0);
    chk("rd_busy3", 64'(busy), 64'h0);
    $display("txn reset during drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_control.md
Name: trap_control

Overview:
- Trap sequencer directly upstream of the mstatus/privilege status block.
- Arbitrates synchronous exceptions and enabled interrupts, latches mepc/mcause/mtval, and drives the one-cycle trapTrigger and trapReturn pulses that the status block consumes.
- Drains the pipeline and issues a redirect PC to fetch, either to mtvec on trap entry or to mepc on mret.

Parameters:
- N, 64, XLEN: width of PC and CSR data.
- FLUSH_CYCLES, 3, number of DRAIN cycles holding flush high before redirect; legal range 1..15.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- excReq  in  16  per-cause synchronous exception requests; bit i means cause code i.
- excPC  in  N  PC of oldest uncommitted instruction; becomes mepc.
- excTval  in  N  faulting address or instruction for mtval.
- irqPending  in  16  mip & mie, per interrupt code.
- mstatusMIE  in  1  mstatus bit 3 from the status block.
- mretReq  in  1  mret reaching commit.
- mtvec  in  N  current mtvec CSR.
- csrWriteEnable  in  3  {mtval, mcause, mepc} software write strobes.
- csrIn  in  N  CSR write data.
- trapTrigger  out  16  one-hot, one-cycle pulse of the accepted cause; feeds the status block.
- trapReturn  out  1  one-cycle pulse on accepted mret; feeds the status block.
- flush  out  1  kill all in-flight instructions.
- busy  out  1  stall commit/fetch while the FSM is not in IDLE.
- redirectValid  out  1  one-cycle redirect strobe to fetch.
- redirectPC  out  N  target PC; valid only while redirectValid is high.
- mepc, mcause, mtval  out  N each  CSR register values.

Behaviour:
- Reset:
  - State IDLE.
  - All outputs and registers 0.
  - Reset in any state aborts the sequence: no redirect is issued and no pulse is emitted on the following cycle.
- FSM states:
  - IDLE: waits for a request.
  - DRAIN: counter runs from FLUSH_CYCLES-1 down to 0.
  - REDIRECT: lasts one cycle, then returns to IDLE.
- Request evaluation: only in IDLE. Requests presented in other states are ignored; the source is being flushed.
- Acceptance priority:
  - Any excReq bit beats any interrupt, and any trap beats mretReq.
  - Among exceptions, the lowest index wins.
  - Interrupts are considered only when mstatusMIE=1; order is 11, then 3, then 7, then remaining bits with the lowest index first.
  - When a trap and mretReq coincide, the mret is dropped.
- Acceptance cycle T, trap case: registers update at the edge ending T.
  - mepc = {excPC[N-1:2], 2'b00}.
  - mcause = {isInterrupt, (N-5) zeros, code[3:0]}.
  - mtval = excTval for exceptions, 0 for interrupts.
- Cycles T+1 .. T+FLUSH_CYCLES (DRAIN):
  - flush=1 and busy=1 throughout.
  - At T+1 only: trapTrigger has the one-hot bit of the accepted code, or trapReturn=1 for mret.
- Cycle T+FLUSH_CYCLES+1 (REDIRECT): redirectValid=1, busy=1, flush=0.
- Redirect target:
  - Trap: {mtvec[N-1:2], 2'b00}.
  - mret: the mepc value.
  - redirectPC is captured at acceptance; a later CSR write does not change it.
- CSR writes:
  - Accepted in any state.
  - mepc write clears bits [1:0].
  - mcause and mtval store csrIn unchanged.
  - A trap acceptance in the same cycle wins over a software write.

Optional Feature:
- Macro: TRAP_VECTORED_MODE_EN.
- Defined:
  - If mtvec[1:0]==2'b01 and the accepted trap is an interrupt, redirectPC = {mtvec[N-1:2],2'b00} + 4*code.
  - Exceptions always use the base address.
  - mtvec[1:0] values 2'b10 and 2'b11 behave as direct.
- Undefined: mtvec[1:0] is ignored and all traps use the base address.

Decomposition:
- Package trap_pkg holds:
  - Exception cause localparams: INST_MISALIGN=0, ILLEGAL=2, BREAKPOINT=3, ECALL_M=11.
  - Interrupt codes: MSI=3, MTI=7, MEI=11.
  - Enum trap_state_t {IDLE, DRAIN, REDIRECT}.
  - MTVEC_DIRECT=2'b00 and MTVEC_VECTORED=2'b01.
- One combinational sub-module, trap_priority_encoder.
  - Inputs: excReq, irqPending, mstatusMIE.
  - Outputs: valid, isInterrupt, code[3:0].
- Register storage uses the existing enable-flop primitives.

Test Plan:
- reset, then excReq=16'h0004, excPC=0x1006, excTval=0xDEAD, mtvec=0x8000_0000 ->
  - Cycle T+1: trapTrigger=16'h0004, mepc=0x1004, mcause=2, mtval=0xDEAD.
  - flush high for 3 cycles.
  - Cycle T+4: redirectValid=1, redirectPC=0x8000_0000.
- irqPending bits 7 and 11 both set, mstatusMIE=1 ->
  - mcause={1,…,11}, trapTrigger=16'h0800, mtval=0.
  - Repeat with mstatusMIE=0: no acceptance, busy stays 0.
- excReq=16'h0800 together with irqPending=16'h0080 and mretReq=1 ->
  - Exception 11 accepted, mcause=11.
  - trapReturn never asserted.
- CSR write mepc=0x2003, then mretReq=1 ->
  - mepc reads 0x2000.
  - trapReturn pulse at T+1.
  - redirectPC=0x2000 at T+4.
- With TRAP_VECTORED_MODE_EN, mtvec=0x8000_0001, interrupt 7 ->
  - redirectPC=0x8000_001C.
  - An exception with the same mtvec redirects to 0x8000_0000.
- reset asserted during DRAIN, and excReq pulsed during DRAIN ->
  - Reset: FSM returns to IDLE, no redirectValid, all outputs 0.
  - excReq pulsed during DRAIN (without reset): ignored, mcause unchanged.
